// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the shift sequencer: FSM states and the {R, L} strobe
// pair that drives the downstream shift register.
package shift_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_SHIFT,
        ST_DONE
    } state_t;

    // Bit 1 is R, bit 0 is L.
    typedef enum logic [1:0] {
        CTL_HOLD  = 2'b00,
        CTL_LEFT  = 2'b01,
        CTL_RIGHT = 2'b10,
        CTL_LOAD  = 2'b11
    } ctl_t;

    function automatic logic is_busy(input state_t s);
        return (s == ST_LOAD) || (s == ST_WAIT) || (s == ST_SHIFT);
    endfunction

endpackage

// File: rtl/shift_sequencer_rate_prescaler.sv
// Loadable down-counter that times the idle gap before each shift strobe.
// It stops at zero instead of wrapping, so the zero flag stays valid.
module shift_sequencer_rate_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [DIV_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - DIV_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/shift_sequencer.sv
// Command sequencer for an N-bit shift register: one parallel load followed by
// a counted series of single-cycle shift strobes at a programmable rate.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 4,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             dir,
    input  logic [N-1:0]     load_val,
    input  logic [CNT_W-1:0] steps,
    input  logic [DIV_W-1:0] rate,
    output logic [N-1:0]     sr_in,
    output logic             sr_R,
    output logic             sr_L,
    output logic             busy,
    output logic             done
);

    state_t           state, state_nx;
    ctl_t             ctl_nx;
    logic             capture, step_dec, pre_load, pre_dec, pre_zero;
    logic             dir_q;
    logic [CNT_W-1:0] steps_q, rem_q;
    logic [DIV_W-1:0] rate_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        step_dec = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    capture  = 1'b1;
                    state_nx = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (steps_q == '0)       state_nx = ST_DONE;
                else if (rate_q == '0)   state_nx = ST_SHIFT;
                else                     state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (pre_zero) state_nx = ST_SHIFT;
            end
            ST_SHIFT: begin
                step_dec = 1'b1;
                if (rem_q == CNT_W'(1))  state_nx = ST_DONE;
                else if (rate_q == '0)   state_nx = ST_SHIFT;
                else                     state_nx = ST_WAIT;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase

        if (abort && state != ST_IDLE) begin
            state_nx = ST_IDLE;
            step_dec = 1'b0;
        end

        // Outputs are registered, so they are decoded from the next state.
        ctl_nx = CTL_HOLD;
        if (state_nx == ST_LOAD)       ctl_nx = CTL_LOAD;
        else if (state_nx == ST_SHIFT) ctl_nx = dir_q ? CTL_LEFT : CTL_RIGHT;
    end

    // A WAIT run of `rate` cycles: load rate-1 on entry, leave when it hits 0.
    assign pre_load = (state_nx == ST_WAIT) && (state != ST_WAIT);
    assign pre_dec  = (state == ST_WAIT);

    shift_sequencer_rate_prescaler #(
        .DIV_W(DIV_W)
    ) u_rate_prescaler (
        .clk     (clk),
        .reset   (reset),
        .load    (pre_load),
        .load_val(rate_q - DIV_W'(1)),
        .dec     (pre_dec),
        .zero    (pre_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dir_q   <= 1'b0;
            steps_q <= '0;
            rate_q  <= '0;
            rem_q   <= '0;
        end else if (capture) begin
            dir_q   <= dir;
            steps_q <= steps;
            rate_q  <= rate;
            rem_q   <= steps;
        end else if (step_dec) begin
            rem_q   <= rem_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_in <= '0;
            sr_R  <= 1'b0;
            sr_L  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            if (capture) sr_in <= load_val;
            {sr_R, sr_L} <= ctl_nx;
            busy <= is_busy(state_nx);
            done <= (state_nx == ST_DONE);
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: table vectors, corner-case sequences and random
// commands checked cycle by cycle against a timeline model of each command.
module tb_shift_sequencer;

    localparam int N     = 8;
    localparam int CNT_W = 4;
    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             reset, start, abort, dir;
    logic [N-1:0]     load_val, sr_in;
    logic [CNT_W-1:0] steps;
    logic [DIV_W-1:0] rate;
    logic             sr_R, sr_L, busy, done;
    logic [N-1:0]     sr_tb;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.N(N), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .abort   (abort),
        .dir     (dir),
        .load_val(load_val),
        .steps   (steps),
        .rate    (rate),
        .sr_in   (sr_in),
        .sr_R    (sr_R),
        .sr_L    (sr_L),
        .busy    (busy),
        .done    (done)
    );

    // Downstream shift register driven by the DUT strobes.
    always @(posedge clk) begin
        case ({sr_R, sr_L})
            2'b11:   sr_tb <= sr_in;
            2'b10:   sr_tb <= sr_tb >> 1;
            2'b01:   sr_tb <= sr_tb << 1;
            default: sr_tb <= sr_tb;
        endcase
    end

    typedef struct {
        logic [7:0] lv;
        logic       d;
        int         s;
        int         r;
        int         exp_done;
        logic [7:0] exp_sr;
    } vec_t;

    vec_t tbl[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [N+3:0] obs();
        return {sr_R, sr_L, busy, done, sr_in};
    endfunction

    // Expected {R, L, busy, done, sr_in} in cycle c after the capture edge:
    // one load, then per step `r` idle cycles and a strobe, then a done cycle.
    function automatic logic [N+3:0] exp_out(input logic [7:0] lv, input logic d,
                                             input int s, input int r, input int c);
        int body;
        body = s * (r + 1);
        if (c == 1) return {2'b11, 1'b1, 1'b0, lv};
        if (c >= 2 && c <= 1 + body) begin
            if ((c - 2) % (r + 1) == r) return {~d, d, 1'b1, 1'b0, lv};
            return {2'b00, 1'b1, 1'b0, lv};
        end
        if (c == 2 + body) return {2'b00, 1'b0, 1'b1, lv};
        return {2'b00, 1'b0, 1'b0, lv};
    endfunction

    function automatic logic [7:0] exp_shift(input logic [7:0] lv, input logic d, input int s);
        logic [7:0] v;
        v = lv;
        for (int i = 0; i < s; i++) v = d ? (v << 1) : (v >> 1);
        return v;
    endfunction

    // Issue one command, scramble the inputs after capture, and compare every
    // cycle through one idle cycle past the done pulse.
    task automatic run_cmd(input logic [7:0] lv, input logic d, input int s, input int r,
                           input string tag, output int done_cyc);
        int len;
        load_val = lv;
        dir      = d;
        steps    = CNT_W'(s);
        rate     = DIV_W'(r);
        start    = 1'b1;
        len      = 2 + s * (r + 1) + 1;
        done_cyc = -1;
        for (int c = 1; c <= len; c++) begin
            tick();
            if (c == 1) begin
                start    = 1'b0;
                load_val = N'($urandom);
                dir      = 1'($urandom);
                steps    = CNT_W'($urandom);
                rate     = DIV_W'($urandom);
            end
            if (done) done_cyc = c;
            check($sformatf("%s c%0d", tag, c), 32'(obs()), 32'(exp_out(lv, d, s, r, c)));
        end
    endtask

    initial begin
        int dc;
        int rs, rr;
        logic [7:0] rlv;
        logic rd;
        logic activity;

        tbl[0] = '{8'hA5, 1'b0, 3, 2, 11, 8'h14};
        tbl[1] = '{8'h01, 1'b1, 4, 0, 6, 8'h10};
        tbl[2] = '{8'h3C, 1'b0, 0, 7, 2, 8'h3C};
        tbl[3] = '{8'h81, 1'b1, 1, 1, 4, 8'h02};
        tbl[4] = '{8'hFF, 1'b0, 15, 0, 17, 8'h00};
        tbl[5] = '{8'hC3, 1'b1, 2, 3, 10, 8'h0C};

        reset = 1'b0; start = 1'b0; abort = 1'b0; dir = 1'b0;
        load_val = '0; steps = '0; rate = '0;
        tick();
        tick();
        check("reset outputs", 32'(obs()), 32'h0);
        reset = 1'b1;
        tick();

        foreach (tbl[i]) begin
            run_cmd(tbl[i].lv, tbl[i].d, tbl[i].s, tbl[i].r, $sformatf("vec%0d", i), dc);
            check($sformatf("vec%0d done cycle", i), 32'(dc), 32'(tbl[i].exp_done));
            check($sformatf("vec%0d final sr", i), 32'(sr_tb), 32'(tbl[i].exp_sr));
        end

        // Asynchronous reset in the middle of a WAIT.
        load_val = 8'h96; dir = 1'b0; steps = 4'd5; rate = 16'd3; start = 1'b1;
        tick();
        start = 1'b0;
        check("rst-wait load", 32'(obs()), 32'(exp_out(8'h96, 1'b0, 5, 3, 1)));
        tick();
        tick();
        check("rst-wait in wait", 32'(obs()), 32'(exp_out(8'h96, 1'b0, 5, 3, 3)));
        reset = 1'b0;
        #1;
        check("rst-wait immediate", 32'(obs()), 32'h0);
        tick();
        tick();
        reset = 1'b1;
        activity = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (done || busy || sr_R || sr_L) activity = 1'b1;
        end
        check("rst-wait no done after", 32'(activity), 32'h0);
        run_cmd(8'h5C, 1'b1, 2, 1, "post-reset", dc);

        // Abort during the second WAIT, then restart in the very next cycle.
        load_val = 8'h5A; dir = 1'b1; steps = 4'd4; rate = 16'd5; start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            start = 1'b0;
            check($sformatf("abort c%0d", c), 32'(obs()), 32'(exp_out(8'h5A, 1'b1, 4, 5, c)));
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort idle", 32'({sr_R, sr_L, busy, done}), 32'h0);
        run_cmd(8'h0F, 1'b0, 3, 5, "after-abort", dc);

        // start held high: second command captured only in the IDLE after done.
        load_val = 8'h5A; dir = 1'b0; steps = 4'd2; rate = 16'd1; start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) begin
                load_val = 8'h33; dir = 1'b1; steps = 4'd1; rate = 16'd0;
            end
            check($sformatf("held A c%0d", c), 32'(obs()), 32'(exp_out(8'h5A, 1'b0, 2, 1, c)));
        end
        for (int c = 1; c <= 4; c++) begin
            tick();
            start = 1'b0;
            check($sformatf("held B c%0d", c), 32'(obs()), 32'(exp_out(8'h33, 1'b1, 1, 0, c)));
        end

        // Random commands against the timeline model and shift arithmetic.
        for (int k = 0; k < 20; k++) begin
            rlv = 8'($urandom);
            rd  = 1'($urandom);
            rs  = int'($urandom_range(0, 15));
            rr  = int'($urandom_range(0, 4));
            run_cmd(rlv, rd, rs, rr, $sformatf("rnd%0d", k), dc);
            check($sformatf("rnd%0d final sr", k), 32'(sr_tb), 32'(exp_shift(rlv, rd, rs)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Control stage directly upstream of the N-bit shift register. It accepts a command (load value, direction, step count, step rate), issues one parallel-load cycle, then issues the requested number of single-cycle shift strobes at a programmable rate. A start/busy/done handshake lets a top-level FSM or test harness drive shift patterns without per-cycle control.

Parameters:
N, 8, data width; matches the width of the downstream shift register.
CNT_W, 4, width of the step-count field; up to 2^CNT_W-1 shifts per command.
DIV_W, 16, width of the rate field; up to 2^DIV_W-1 idle cycles between shifts.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset).
start  input  1  command request; sampled only in IDLE.
abort  input  1  synchronous cancel; returns to IDLE without a done pulse.
dir  input  1  shift direction: 0 = right, 1 = left.
load_val  input  N  value to parallel-load into the shift register.
steps  input  CNT_W  number of shift strobes to issue.
rate  input  DIV_W  idle cycles inserted before each shift strobe.
sr_in  output  N  parallel data to the shift register.
sr_R  output  1  right/load strobe to the shift register.
sr_L  output  1  left/load strobe to the shift register.
busy  output  1  high in LOAD, WAIT and SHIFT.
done  output  1  one-cycle completion pulse.

Behaviour:
- Shift register control encoding: R=0,L=0 hold; R=1,L=0 shift right; R=0,L=1 shift left; R=1,L=1 parallel load of sr_in.
- All outputs are registered. When reset is low: state=IDLE, sr_in=0, sr_R=0, sr_L=0, busy=0, done=0, and all counters are 0. Reset asserted mid-command aborts immediately; no done pulse follows.
- States: IDLE, LOAD, WAIT, SHIFT, DONE.
- IDLE: when start=1 and abort=0, capture load_val, dir, steps and rate into holding registers, then go to LOAD. The inputs may change after the capture edge.
- LOAD (1 cycle): sr_R=sr_L=1 and sr_in=captured value. Next state:
  - DONE if steps=0;
  - SHIFT if rate=0;
  - WAIT otherwise.
- WAIT: sr_R=sr_L=0. Hold for exactly rate cycles (prescaler counts rate-1 down to 0), then go to SHIFT.
- SHIFT (1 cycle): sr_R=~dir and sr_L=dir. Decrement the remaining count. If the remaining count was 1, go to DONE. Otherwise go to WAIT (rate>0) or stay in SHIFT (rate=0, giving back-to-back strobes).
- DONE (1 cycle): done=1, busy=0, strobes 0, then IDLE. A start in the DONE cycle is ignored.
- sr_in holds the last loaded value until the next LOAD.
- Total cycles from the capture edge to the done pulse: 1 + steps*(rate+1) + 1.
- start while busy or in DONE: ignored, with no queuing.
- abort=1 in any non-IDLE state: next state IDLE, strobes 0, busy 0, no done. abort has priority over start in IDLE.
- sr_R and sr_L are never both 1 outside LOAD.

Decomposition:
- Shared package: state encoding constants (ST_IDLE..ST_DONE) and the control encoding constants (CTL_HOLD, CTL_RIGHT, CTL_LEFT, CTL_LOAD).
- One natural sub-module: rate_prescaler (loadable DIV_W-bit down-counter with a zero flag), used for WAIT.
- The step counter stays inline.

Test Plan:
- Reset: drive reset=0 mid-WAIT with steps=5, rate=3 -> all outputs 0 at once; after release, state is IDLE and no done pulse appears.
- start, load_val=8'hA5, dir=0, steps=3, rate=2 -> LOAD on cycle 1 (R=L=1, sr_in=A5); R-only strobes on cycles 4, 7 and 10; done on cycle 11; busy high on cycles 1-10.
- dir=1, steps=4, rate=0 -> L-only strobes on 4 consecutive cycles (2-5); done on cycle 6; with the shift register attached, 8'h01 becomes 8'h10.
- steps=0, load_val=8'h3C -> one LOAD cycle, then done on the next cycle; no shift strobes.
- abort asserted during the second WAIT of steps=4, rate=5 -> IDLE next cycle, no done; a new start is accepted immediately afterwards.
- start held high continuously with steps=2, rate=1 -> the second command is captured only in the IDLE cycle after done; start pulses during busy do not alter the captured parameters.
